// File: rtl/risc_loader_ctrl_if.sv
// Loader stream + memory external-port bundle.
// master: loader side; slave: stream source and memory side.
interface risc_loader_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] mem_out;

  modport master (
    input  in_valid, in_data, mem_out,
    output in_ready, ext_we, ext_addr, ext_data
  );

  modport slave (
    output in_valid, in_data, mem_out,
    input  in_ready, ext_we, ext_addr, ext_data
  );
endinterface

// File: rtl/risc_loader_ctrl.sv
// Program loader: streams words into memory, holds the CPU in reset,
// then runs it until halt.
// Ports: clk, reset_n (async low), start/abort, base_addr, word_cnt,
// bus (stream in + memory port), test_normal, cpu_reset_n, cpu_done,
// busy, halted, verify_err, run_cycles.
// Optional readback verify: define RISC_LOADER_VERIFY_EN.
module risc_loader_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int CNT_W      = 8,
  parameter int RST_CYCLES = 9,
  parameter int RUN_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  risc_loader_ctrl_if.master bus,
  output logic              test_normal,
  output logic              cpu_reset_n,
  input  logic              cpu_done,
  output logic              busy,
  output logic              halted,
  output logic              verify_err,
  output logic [RUN_W-1:0]  run_cycles
);

  localparam int HC_W =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HC_W-1:0] HC_LAST =
    HC_W'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, VERIFY, HOLD, RUN, HALT
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  idx_q;
  logic [DATA_W-1:0] sum_q;
  logic [HC_W-1:0]   hcnt_q;
  logic [RUN_W-1:0]  run_q;
  logic              halted_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              accept;
  logic              hs;

`ifdef RISC_LOADER_VERIFY_EN
  logic [CNT_W-1:0]  ridx_q;
  logic              p1_q;
  logic              p2_q;
  logic [DATA_W-1:0] vsum_q;
  logic              verr_q;
  logic              vdone;

  // all reads issued and both pipe slots drained
  assign vdone = (ridx_q == len_q) && !p1_q && !p2_q;
  assign verify_err = verr_q;
`else
  logic unused_sum;

  assign unused_sum = ^{sum_q, bus.mem_out};
  assign verify_err = 1'b0;
`endif

  assign accept = start && !abort &&
                  (state == IDLE || state == HALT);

  // idx==len marks the drain cycle carrying the final write
  assign bus.in_ready = (state == LOAD) &&
                        (idx_q != len_q) && !abort;
  assign hs = bus.in_valid && bus.in_ready;

  assign bus.ext_we   = we_q;
  assign bus.ext_addr = addr_q;
  assign bus.ext_data = data_q;

  assign test_normal = (state == IDLE) || (state == LOAD) ||
                       (state == VERIFY);
  assign cpu_reset_n = (state == RUN) || (state == HALT);
  assign busy        = (state == LOAD) || (state == VERIFY) ||
                       (state == HOLD) || (state == RUN);
  assign halted      = halted_q;
  assign run_cycles  = run_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, HALT: begin
        if (accept)
          state_n = (word_cnt == '0) ? HOLD : LOAD;
      end
      LOAD: begin
        if (idx_q == len_q) begin
`ifdef RISC_LOADER_VERIFY_EN
          state_n = VERIFY;
`else
          state_n = HOLD;
`endif
        end
      end
`ifdef RISC_LOADER_VERIFY_EN
      VERIFY: if (vdone) state_n = HOLD;
`endif
      HOLD: if (hcnt_q == HC_LAST) state_n = RUN;
      RUN:  if (cpu_done) state_n = HALT;
      default: state_n = state;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      sum_q    <= '0;
      hcnt_q   <= '0;
      run_q    <= '0;
      halted_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
`ifdef RISC_LOADER_VERIFY_EN
      ridx_q   <= '0;
      p1_q     <= 1'b0;
      p2_q     <= 1'b0;
      vsum_q   <= '0;
      verr_q   <= 1'b0;
`endif
    end else begin
      we_q <= hs;
      if (hs) begin
        addr_q <= base_q + ADDR_W'(idx_q);
        data_q <= bus.in_data;
        idx_q  <= idx_q + 1'b1;
        sum_q  <= sum_q + bus.in_data;
      end
      hcnt_q <= (state == HOLD) ? hcnt_q + 1'b1 : '0;
      if (state == RUN && run_q != '1)
        run_q <= run_q + 1'b1;
      if (state == RUN && cpu_done && !abort)
        halted_q <= 1'b1;
`ifdef RISC_LOADER_VERIFY_EN
      // p1: read address on the port, p2: its data on mem_out
      p1_q <= 1'b0;
      p2_q <= p1_q;
      if (state == VERIFY && ridx_q != len_q) begin
        addr_q <= base_q + ADDR_W'(ridx_q);
        ridx_q <= ridx_q + 1'b1;
        p1_q   <= 1'b1;
      end
      if (p2_q)
        vsum_q <= vsum_q + bus.mem_out;
      if (state == VERIFY && vdone && !abort)
        verr_q <= (vsum_q != sum_q);
`endif
      if (accept) begin
        base_q   <= base_addr;
        len_q    <= word_cnt;
        idx_q    <= '0;
        sum_q    <= '0;
        run_q    <= '0;
        halted_q <= 1'b0;
`ifdef RISC_LOADER_VERIFY_EN
        ridx_q   <= '0;
        p1_q     <= 1'b0;
        p2_q     <= 1'b0;
        vsum_q   <= '0;
        verr_q   <= 1'b0;
`endif
      end
    end
  end

endmodule
